// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared types and constants for the result display
// FSM states, digit codes, segment patterns and the result-to-digit formatter.
package display_pkg;

    typedef enum logic [1:0] {
        ST_BLANK,
        ST_LOAD,
        ST_SHOW,
        ST_ERR
    } state_e;

    typedef logic [3:0][3:0] digits_t;

    localparam logic [3:0] DIG_MINUS = 4'd10;
    localparam logic [3:0] DIG_E     = 4'd11;
    localparam logic [3:0] DIG_R     = 4'd12;
    localparam logic [3:0] DIG_BLANK = 4'd15;

    // Active-low, bit 0 = segment a ... bit 6 = segment g.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_R     = 7'b0101111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Digit 3 is the leftmost position; a zero result never carries a minus sign.
    function automatic digits_t format_digits(input logic [4:0] res,
                                              input logic       dbz,
                                              input logic       zro);
        logic [3:0] mag;
        logic [3:0] ones;
        logic       ten;
        digits_t    d;
        mag  = res[3:0];
        ten  = (mag >= 4'd10);
        ones = ten ? (mag - 4'd10) : mag;
        if (dbz) begin
            d = {DIG_BLANK, DIG_E, DIG_R, DIG_R};
        end else if (zro || (mag == 4'd0)) begin
            d = {DIG_BLANK, DIG_BLANK, DIG_BLANK, 4'd0};
        end else begin
            d = {DIG_BLANK,
                 res[4] ? DIG_MINUS : DIG_BLANK,
                 ten ? 4'd1 : DIG_BLANK,
                 ones};
        end
        return d;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - digit code to active-low seven-segment pattern
// Purely combinational; unused codes 13 and 14 show nothing.
module seg7_decode
    import display_pkg::*;
(
    input  logic [3:0] code_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (code_i)
            4'd0:      seg_o = SEG_0;
            4'd1:      seg_o = SEG_1;
            4'd2:      seg_o = SEG_2;
            4'd3:      seg_o = SEG_3;
            4'd4:      seg_o = SEG_4;
            4'd5:      seg_o = SEG_5;
            4'd6:      seg_o = SEG_6;
            4'd7:      seg_o = SEG_7;
            4'd8:      seg_o = SEG_8;
            4'd9:      seg_o = SEG_9;
            DIG_MINUS: seg_o = SEG_MINUS;
            DIG_E:     seg_o = SEG_E;
            DIG_R:     seg_o = SEG_R;
            default:   seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/result_display.sv
// rtl/result_display.sv - calculator result capture and 4-digit multiplexed display
// Accepts a signed-magnitude result, formats it, and scans it onto a common-anode display.
module result_display
    import display_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       res_valid,
    input  logic [4:0] result,
    input  logic       divbyzero,
    input  logic       zero,
    output logic       res_ready,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [RW-1:0] REF_LAST   = RW'(REFRESH_DIV - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    state_e        state_q;
    logic          ready_q;
    logic [4:0]    cap_result_q;
    logic          cap_dbz_q;
    logic          cap_zero_q;
    digits_t       digits_q;

    logic [RW-1:0] refresh_q;
    logic [1:0]    idx_q;
    logic [FW-1:0] frame_q;
    logic          blink_q;

    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic [6:0]    dec_seg;

    logic accept;
    logic enter_err;
    logic ref_wrap;
    logic idx_wrap;
    logic frame_wrap;
    logic blank_now;

    assign accept     = res_valid && ready_q;
    assign enter_err  = (state_q == ST_LOAD) && cap_dbz_q;
    assign ref_wrap   = (refresh_q == REF_LAST);
    assign idx_wrap   = ref_wrap && (idx_q == 2'd3);
    assign frame_wrap = idx_wrap && (frame_q == FRAME_LAST);
    assign blank_now  = (state_q == ST_BLANK) || ((state_q == ST_ERR) && blink_q);

    // Control FSM: capture on accept, format for exactly one LOAD cycle, then hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_BLANK;
            ready_q      <= 1'b1;
            cap_result_q <= 5'd0;
            cap_dbz_q    <= 1'b0;
            cap_zero_q   <= 1'b0;
            digits_q     <= {DIG_BLANK, DIG_BLANK, DIG_BLANK, DIG_BLANK};
        end else begin
            case (state_q)
                ST_LOAD: begin
                    digits_q <= format_digits(cap_result_q, cap_dbz_q, cap_zero_q);
                    ready_q  <= 1'b1;
                    state_q  <= cap_dbz_q ? ST_ERR : ST_SHOW;
                end
                default: begin
                    if (accept) begin
                        cap_result_q <= result;
                        cap_dbz_q    <= divbyzero;
                        cap_zero_q   <= zero;
                        ready_q      <= 1'b0;
                        state_q      <= ST_LOAD;
                    end
                end
            endcase
        end
    end

    // Scan timing runs free in every state; only the blink timing restarts on ERR entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_q <= '0;
            idx_q     <= 2'd0;
            frame_q   <= '0;
            blink_q   <= 1'b0;
        end else begin
            refresh_q <= ref_wrap ? '0 : (refresh_q + 1'b1);
            if (ref_wrap) begin
                idx_q <= idx_q + 2'd1;
            end
            if (enter_err) begin
                frame_q <= '0;
                blink_q <= 1'b0;
            end else begin
                if (idx_wrap) begin
                    frame_q <= frame_wrap ? '0 : (frame_q + 1'b1);
                end
                if (frame_wrap) begin
                    blink_q <= ~blink_q;
                end
            end
        end
    end

    seg7_decode u_decode (
        .code_i (digits_q[idx_q]),
        .seg_o  (dec_seg)
    );

    always_comb begin
        an_d  = 4'b1111;
        seg_d = SEG_BLANK;
        if (!blank_now) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = dec_seg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_q  <= 4'b1111;
            seg_q <= SEG_BLANK;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign res_ready = ready_q;
    assign an        = an_q;
    assign seg       = seg_q;
    assign dp        = 1'b1;

endmodule
